mem_port_arbiter: RTL and testbench

- Shares the processor's single-port unified memory between instruction fetch (IF) and data load/store (DM).
- Sits between the processor core and the memory array:
  - Arbitrates simultaneous requests round-robin.
  - Issues one memory access at a time.
  - Waits a fixed memory latency, then returns registered read data with a one-cycle valid pulse to the owner.

---
 rtl/mem_port_arbiter.sv | 111 +++++++++++
 tb/tb_mem_port_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch and data access.
// One access in flight at a time; read data is registered and flagged with a one-cycle rvalid.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned MEM_LAT = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_gnt,
   output logic              dm_rvalid,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam int unsigned CNT_W = $clog2(MEM_LAT) + 1;

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             last_owner;  // 0 = IF, 1 = DM
   logic             owner;
   logic             owner_we;
   logic             arb_open;
   logic             gnt_if;
   logic             gnt_dm;

   // Grants are suppressed while reset is held so every output reads 0.
   assign arb_open = reset && ((state == StIdle) || (state == StResp));
   assign gnt_dm   = arb_open && dm_req && (!if_req || !last_owner);
   assign gnt_if   = arb_open && if_req && (!dm_req || last_owner);

   assign if_gnt = gnt_if;
   assign dm_gnt = gnt_dm;
   assign busy   = (state != StIdle);

   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (gnt_if) begin
         mem_en   = 1'b1;
         mem_addr = if_addr;
      end else if (gnt_dm) begin
         mem_en    = 1'b1;
         mem_we    = dm_we;
         mem_addr  = dm_addr;
         mem_wdata = dm_wdata;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= StIdle;
         cnt        <= '0;
         last_owner <= 1'b0;
         owner      <= 1'b0;
         owner_we   <= 1'b0;
         if_rvalid  <= 1'b0;
         dm_rvalid  <= 1'b0;
         if_rdata   <= '0;
         dm_rdata   <= '0;
      end else begin
         if_rvalid <= 1'b0;
         dm_rvalid <= 1'b0;
         unique case (state)
            StIdle, StResp: begin
               if (gnt_if || gnt_dm) begin
                  owner      <= gnt_dm;
                  owner_we   <= gnt_dm && dm_we;
                  last_owner <= gnt_dm;
                  cnt        <= CNT_W'(MEM_LAT - 1);
                  state      <= StWait;
               end else begin
                  state <= StIdle;
               end
            end
            StWait: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  // Stores complete without disturbing the last load result.
                  if (!owner)         if_rdata <= mem_rdata;
                  else if (!owner_we) dm_rdata <= mem_rdata;
                  if_rvalid <= !owner;
                  dm_rvalid <= owner;
                  state     <= StResp;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run
// against a transaction-level model of grant times, response times and memory contents.
module tb_mem_port_arbiter;

   localparam int unsigned L0 = 2;
   localparam int unsigned L1 = 1;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] cyc = '0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // DUT with MEM_LAT = 2
   logic        if_req, if_gnt, if_rvalid;
   logic [31:0] if_addr, if_rdata;
   logic        dm_req, dm_we, dm_gnt, dm_rvalid;
   logic [31:0] dm_addr, dm_wdata, dm_rdata;
   logic        mem_en, mem_we, busy;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   // DUT with MEM_LAT = 1
   logic        if1_req, if1_gnt, if1_rvalid;
   logic [31:0] if1_addr, if1_rdata;
   logic        dm1_req, dm1_we, dm1_gnt, dm1_rvalid;
   logic [31:0] dm1_addr, dm1_wdata, dm1_rdata;
   logic        m1_en, m1_we, busy1;
   logic [31:0] m1_addr, m1_wdata, m1_rdata;

   logic [70:0] obs, obs1;
   assign obs  = {if_gnt, dm_gnt, mem_en, mem_we, mem_addr, mem_wdata, if_rvalid, dm_rvalid, busy};
   assign obs1 = {if1_gnt, dm1_gnt, m1_en, m1_we, m1_addr, m1_wdata, if1_rvalid, dm1_rvalid, busy1};

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L0)) u0 (
      .clock(clk), .reset(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
      .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L1)) u1 (
      .clock(clk), .reset(rst_n),
      .if_req(if1_req), .if_addr(if1_addr), .if_gnt(if1_gnt), .if_rvalid(if1_rvalid),
      .if_rdata(if1_rdata),
      .dm_req(dm1_req), .dm_we(dm1_we), .dm_addr(dm1_addr), .dm_wdata(dm1_wdata),
      .dm_gnt(dm1_gnt), .dm_rvalid(dm1_rvalid), .dm_rdata(dm1_rdata),
      .mem_en(m1_en), .mem_we(m1_we), .mem_addr(m1_addr), .mem_wdata(m1_wdata),
      .mem_rdata(m1_rdata), .busy(busy1)
   );

   function automatic logic [31:0] init_word(int i);
      logic [7:0] b;
      b = 8'(i);
      if (i == 'h10) return 32'h0050_0093;
      return {b, ~b, b ^ 8'h5A, 8'h3C};
   endfunction

   // Memory array: read data is only valid exactly MEM_LAT cycles after the issue edge.
   logic [31:0] mem [256];
   bit          mem_init = 1'b0;
   logic        v0a = 1'b0, v0b = 1'b0, v1a = 1'b0;
   logic [31:0] d0a, d0b, d1a;

   always @(posedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
         mem_init <= 1'b1;
      end else if (mem_en && mem_we) begin
         mem[mem_addr[7:0]] <= mem_wdata;
      end
      v0a <= mem_en && !mem_we;
      d0a <= mem[mem_addr[7:0]];
      v0b <= v0a;
      d0b <= d0a;
      v1a <= m1_en && !m1_we;
      d1a <= mem[m1_addr[7:0]];
   end

   assign mem_rdata = v0b ? d0b : {16'hBAD0, cyc[15:0]};
   assign m1_rdata  = v1a ? d1a : {16'hBAD1, cyc[15:0]};

   logic [31:0] ref_mem [256];
   int          n_checks = 0;
   int          n_pass   = 0;
   logic [31:0] exp_dm_reg;

   task automatic pulse_reset();
      @(negedge clk);
      rst_n = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; if1_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      if_req = 1'b1; if_addr = 32'h8;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h20; dm_wdata = '0;
      if1_req = 1'b0; if1_addr = '0;
      dm1_req = 1'b0; dm1_we = 1'b0; dm1_addr = '0; dm1_wdata = '0;
      repeat (3) @(negedge clk);
      #1;
      n_checks++;
      if (obs !== '0 || if_rdata !== '0 || dm_rdata !== '0)
         $display("FAIL reset_outputs: got %h if_rdata=%h dm_rdata=%h, want all 0",
                  obs, if_rdata, dm_rdata);
      else n_pass++;
      n_checks++;
      if (obs1 !== '0 || if1_rdata !== '0)
         $display("FAIL reset_outputs_lat1: got %h if_rdata=%h, want all 0", obs1, if1_rdata);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (obs !== {1'b0, 1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 3'b000})
         $display("FAIL reset_first_grant: got %h, want dm_gnt with addr 0x20", obs);
      else n_pass++;
      @(negedge clk);
      if_req = 1'b0; dm_req = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      exp_dm_reg = ref_mem[8'h20];
      n_checks++;
      if ({dm_rvalid, dm_rdata} !== {1'b1, exp_dm_reg})
         $display("FAIL reset_first_load: got rvalid=%b rdata=%h, want 1 %h",
                  dm_rvalid, dm_rdata, exp_dm_reg);
      else n_pass++;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_fetch();
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h10;
      #1;
      n_checks++;
      if ({if_gnt, dm_gnt, mem_en, mem_we, mem_addr} !== {4'b1010, 32'h10})
         $display("FAIL fetch_grant: got gnt=%b%b en=%b we=%b addr=%h, want 1 0 1 0 00000010",
                  if_gnt, dm_gnt, mem_en, mem_we, mem_addr);
      else n_pass++;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (k == 1) begin if_req = 1'b0; if_addr = 32'hFFFF_FFF0; end
         #1;
         n_checks++;
         if ({mem_en, if_rvalid, dm_rvalid, busy} !== {1'b0, k == 3, 1'b0, k <= 3})
            $display("FAIL fetch_t%0d: got en=%b rv=%b%b busy=%b, want 0 %b0 %b",
                     k, mem_en, if_rvalid, dm_rvalid, busy, k == 3, k <= 3);
         else n_pass++;
         if (k == 3) begin
            n_checks++;
            if (if_rdata !== 32'h0050_0093)
               $display("FAIL fetch_data: got %h want 00500093", if_rdata);
            else n_pass++;
         end
      end
   endtask

   task automatic test_store();
      @(negedge clk);
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'hDEAD_BEEF;
      #1;
      n_checks++;
      if (obs !== {1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 3'b000})
         $display("FAIL store_grant: got %h, want dm store addr 0x40 data deadbeef", obs);
      else n_pass++;
      ref_mem[8'h40] = 32'hDEAD_BEEF;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (k == 1) begin dm_req = 1'b0; dm_we = 1'b0; dm_wdata = 32'h1234_5678; end
         #1;
         n_checks++;
         if ({mem_en, if_rvalid, dm_rvalid, busy, dm_rdata} !==
             {1'b0, 1'b0, k == 3, k <= 3, exp_dm_reg})
            $display("FAIL store_t%0d: got en=%b rv=%b%b busy=%b rdata=%h, want 0 0%b %b %h",
                     k, mem_en, if_rvalid, dm_rvalid, busy, dm_rdata, k == 3, k <= 3,
                     exp_dm_reg);
         else n_pass++;
      end
   endtask

   task automatic test_contention();
      pulse_reset();
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h11;
      dm_req = 1'b1; dm_addr = 32'h22; dm_we = 1'b0;
      for (int k = 0; k < 12; k++) begin
         #1;
         n_checks++;
         if ({if_gnt, dm_gnt, if_rvalid, dm_rvalid, busy} !==
             {k == 3 || k == 9, k == 0 || k == 6, k == 6, k == 3 || k == 9, k >= 1})
            $display("FAIL contention_t%0d: got gnt=%b%b rv=%b%b busy=%b", k, if_gnt, dm_gnt,
                     if_rvalid, dm_rvalid, busy);
         else n_pass++;
         @(negedge clk);
      end
      if_req = 1'b0; dm_req = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if1_req  = (k < 6);
         if1_addr = 32'h30 + 32'(k);
         #1;
         n_checks++;
         if ({if1_gnt, m1_en, if1_rvalid, busy1} !==
             {k % 2 == 0 && k < 6, k % 2 == 0 && k < 6, k >= 2 && k % 2 == 0, k >= 1 && k <= 6})
            $display("FAIL b2b_t%0d: got gnt=%b en=%b rv=%b busy=%b", k, if1_gnt, m1_en,
                     if1_rvalid, busy1);
         else n_pass++;
         if (k >= 2 && k % 2 == 0) begin
            n_checks++;
            if (if1_rdata !== ref_mem[8'(8'h30 + k - 2)])
               $display("FAIL b2b_data_t%0d: got %h want %h", k, if1_rdata,
                        ref_mem[8'(8'h30 + k - 2)]);
            else n_pass++;
         end
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h55;
      #1;
      n_checks++;
      if (dm_gnt !== 1'b1) $display("FAIL midreset_grant: got %b want 1", dm_gnt);
      else n_pass++;
      @(negedge clk);
      dm_req = 1'b0;
      rst_n  = 1'b0;
      #1;
      n_checks++;
      if (obs !== '0 || dm_rdata !== '0)
         $display("FAIL midreset_clear: got %h dm_rdata=%h, want all 0", obs, dm_rdata);
      else n_pass++;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (k == 2) rst_n = 1'b1;
         #1;
         n_checks++;
         if ({dm_rvalid, if_rvalid, busy, dm_rdata} !== {3'b000, 32'h0})
            $display("FAIL midreset_quiet_t%0d: got rv=%b%b busy=%b rdata=%h, want 000 0", k,
                     dm_rvalid, if_rvalid, busy, dm_rdata);
         else n_pass++;
      end
      @(negedge clk);
      dm_req = 1'b1; dm_addr = 32'h66;
      #1;
      n_checks++;
      if ({dm_gnt, mem_addr} !== {1'b1, 32'h66})
         $display("FAIL midreset_regrant: got gnt=%b addr=%h want 1 00000066", dm_gnt, mem_addr);
      else n_pass++;
      @(negedge clk);
      dm_req = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      n_checks++;
      if ({dm_rvalid, dm_rdata} !== {1'b1, ref_mem[8'h66]})
         $display("FAIL midreset_load: got rv=%b rdata=%h want 1 %h", dm_rvalid, dm_rdata,
                  ref_mem[8'h66]);
      else n_pass++;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_random();
      int          g_c, r_c;
      logic        own, own_we, last, win, gi, gd, busy_e, rvi, rvd;
      logic        if_p, dm_p, dwe;
      logic [31:0] ia, da, dw, pend, e_if, e_dm;
      logic [70:0] e;
      g_c = -100; r_c = -100;
      own = 1'b0; own_we = 1'b0; last = 1'b0; win = 1'b0;
      if_p = 1'b0; dm_p = 1'b0; dwe = 1'b0;
      ia = '0; da = '0; dw = '0; pend = '0; e_if = '0; e_dm = '0;
      pulse_reset();
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         if (!if_p && $urandom_range(0, 2) == 0) begin
            if_p = 1'b1; ia = 32'($urandom_range(0, 255));
         end
         if (!dm_p && $urandom_range(0, 2) == 0) begin
            dm_p = 1'b1; da = 32'($urandom_range(0, 255));
            dwe = 1'($urandom_range(0, 1)); dw = $urandom;
         end
         if_req   = if_p;
         if_addr  = if_p ? ia : $urandom;
         dm_req   = dm_p;
         dm_addr  = dm_p ? da : $urandom;
         dm_we    = dm_p ? dwe : 1'($urandom_range(0, 1));
         dm_wdata = dm_p ? dw : $urandom;
         #1;
         busy_e = (c > g_c) && (c <= r_c);
         rvi    = (c == r_c) && !own;
         rvd    = (c == r_c) && own;
         if (c == r_c) begin
            if (!own) e_if = pend;
            else if (!own_we) e_dm = pend;
         end
         gi = 1'b0; gd = 1'b0;
         if (c >= r_c && (if_p || dm_p)) begin
            win = (if_p && dm_p) ? !last : dm_p;
            gi = !win; gd = win;
         end
         e = {gi, gd, gi | gd, gd & dwe, gi ? ia : (gd ? da : 32'h0), gd ? dw : 32'h0,
              rvi, rvd, busy_e};
         n_checks++;
         if (obs !== e) $display("FAIL random_bus_c%0d: got %h want %h", c, obs, e);
         else n_pass++;
         n_checks++;
         if ({if_rdata, dm_rdata} !== {e_if, e_dm})
            $display("FAIL random_rdata_c%0d: got %h %h want %h %h", c, if_rdata, dm_rdata,
                     e_if, e_dm);
         else n_pass++;
         if (gi || gd) begin
            g_c = c; r_c = c + int'(L0) + 1;
            own = gd; own_we = gd & dwe; last = gd;
            if (gi) begin
               pend = ref_mem[ia[7:0]]; if_p = 1'b0;
            end else begin
               if (dwe) ref_mem[da[7:0]] = dw;
               else pend = ref_mem[da[7:0]];
               dm_p = 1'b0;
            end
         end
      end
      @(negedge clk);
      if_req = 1'b0; dm_req = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
      exp_dm_reg = '0;
      test_reset();
      test_fetch();
      test_store();
      test_contention();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
